multicycle_control: RTL and testbench
=====================================

# multicycle_control

Moore-style control FSM for the multicycle CPU. It drives every control input of `datapath` from the instruction register contents (`IReg_out`). It sequences each instruction through fetch, decode, execute, memory and write-back cycles. It is instantiated beside `datapath` in the CPU top level and replaces the hand-driven control stimulus used in datapath-only benches.

## Interface
Parameters:
- none. All encodings are constants in the shared package.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; one clock; sampled on rising edge of clk
- IReg_out  input  32  instruction register from datapath; opcode [31:26], funct [5:0]
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA, RegWrite, RegDst  output  1 each  datapath controls
- PCSource  output  2  00 ALU result, 01 ALUOut, 10 jump target {PC[31:28], IR[25:0], 2'b00}
- ALUSrcB  output  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- ALUOp  output  4  ALU function: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111
- halted  output  1  FSM in HALT (illegal instruction)
- instr_count  output  32  retired-instruction counter

## Operation
- Supported opcodes:
  - R-type 000000, with funct add 100000, sub 100010, and 100100, or 100101, slt 101010
  - ADDI 001000, ANDI 001100, ORI 001101, SLTI 001010
  - LW 100011, SW 101011, BEQ 000100, J 000010
- States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP, HALT.
- Every control is 0 in every state unless it is listed below.
- IDLE: all controls 0. Next state is FETCH.
- FETCH: MemRead=1, IRWrite=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD, PCSource=00, PCWrite=1. Next state is DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=ADD (branch target into ALUOut). Next state by opcode:
  - LW or SW → MEM_ADDR
  - R-type → R_EXEC
  - I-ALU → I_EXEC
  - BEQ → BRANCH
  - J → JUMP
  - anything else, including an R-type with an unlisted funct → HALT
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=ADD. Next state is MEM_RD for LW, MEM_WR for SW.
- MEM_RD: MemRead=1, IorD=1. Next state is MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0. Next state is FETCH.
- MEM_WR: MemWrite=1, IorD=1. Next state is FETCH.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp from funct. Next state is R_WB.
- R_WB: RegWrite=1, RegDst=1, MemtoReg=0. Next state is FETCH.
- I_EXEC: ALUSrcA=1, ALUSrcB=10. ALUOp from opcode: ADDI→ADD, ANDI→AND, ORI→OR, SLTI→SLT. Next state is I_WB.
- I_WB: RegWrite=1, RegDst=0, MemtoReg=0. Next state is FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=SUB, PCWriteCond=1, PCSource=01. Next state is FETCH.
- JUMP: PCWrite=1, PCSource=10. Next state is FETCH.
- HALT: all controls 0, halted=1. Stays in HALT until reset.
- instr_count increments by 1 on every transition from a final state into FETCH. It wraps from 32'hFFFF_FFFF to 0.

## Timing
- Reset: when reset is high at an edge, the next state is IDLE and instr_count is 0. Reset takes priority over every transition, including in HALT and mid-instruction.
- All controls are decoded combinationally from the state register only, so there is no IReg_out-to-output path except ALUOp in R_EXEC and I_EXEC, and the next-state logic.
- After reset: all outputs 0 and halted=0.
- IReg_out is used from DECODE onward; the IR is loaded at the FETCH edge.
- Cycles per instruction, FETCH included:
  - BEQ 3, J 3
  - R-type 4, I-ALU 4, SW 4
  - LW 5
- The first FETCH happens one cycle after reset is released.

## Structure
- Package `cpu_pkg` holds:
  - opcode and funct constants
  - ALUOp codes
  - ALUSrcB and PCSource codes
  - the state enumeration
- Sub-module `alu_op_decode`: combinational opcode/funct → ALUOp mapping plus a legal flag. It is reusable by a later pipelined control.
- `multicycle_control` holds the state register, next-state logic, output decode and instr_count.

## Test plan
- Reset, then IR=32'h01095020 (add): states IDLE, FETCH, DECODE, R_EXEC with ALUOp=0010, then R_WB with RegWrite=1, RegDst=1. instr_count=1 on re-entry to FETCH.
- IR=32'h8D090004 (lw): 5-cycle sequence. MEM_RD has MemRead=1, IorD=1. MEM_WB has MemtoReg=1, RegDst=0.
- IR=32'hAD090004 (sw), then 32'h11090003 (beq): MemWrite=1 for exactly one cycle. BRANCH has PCWriteCond=1, PCSource=01, ALUOp=0110. instr_count advances by 2.
- IR=32'h08000010 (j): JUMP has PCWrite=1, PCSource=10. Total of 3 cycles.
- IR=32'hFC000000, then IR=32'h0109502F (bad funct): HALT with halted=1 and all controls 0. HALT holds for 20 cycles and instr_count stays unchanged; reset returns to IDLE.
- Assert reset during MEM_RD of an lw: next state is IDLE, all outputs 0, instr_count=0, no RegWrite pulse.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle CPU: opcodes, functs, ALU/mux codes and control states.
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
        S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB, S_BRANCH, S_JUMP, S_HALT
    } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Maps opcode/funct to an ALU function; legal marks a recognised R-type or I-ALU operation.
module alu_op_decode
    import cpu_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] alu_op,
    output logic       legal
);

    always_comb begin
        alu_op = ALU_ADD;
        legal  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                legal = 1'b1;
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: legal  = 1'b0;
                endcase
            end
            OP_ADDI: begin alu_op = ALU_ADD; legal = 1'b1; end
            OP_ANDI: begin alu_op = ALU_AND; legal = 1'b1; end
            OP_ORI:  begin alu_op = ALU_OR;  legal = 1'b1; end
            OP_SLTI: begin alu_op = ALU_SLT; legal = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle datapath; sequences fetch/decode/execute/mem/write-back.
module multicycle_control
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IReg_out,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        MemtoReg,
    output logic        ALUSrcA,
    output logic        RegWrite,
    output logic        RegDst,
    output logic [1:0]  PCSource,
    output logic [1:0]  ALUSrcB,
    output logic [3:0]  ALUOp,
    output logic        halted,
    output logic [31:0] instr_count
);

    state_t     state, next_state;
    logic [5:0] opcode, funct;
    logic [3:0] dec_alu_op;
    logic       dec_legal;
    logic       unused_ir_bits;

    assign opcode         = IReg_out[31:26];
    assign funct          = IReg_out[5:0];
    assign unused_ir_bits = ^IReg_out[25:6];

    alu_op_decode u_alu_op_decode (
        .opcode (opcode),
        .funct  (funct),
        .alu_op (dec_alu_op),
        .legal  (dec_legal)
    );

    // Entering FETCH from anything but IDLE means an instruction just retired.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            instr_count <= 32'd0;
        end else begin
            state <= next_state;
            if (next_state == S_FETCH && state != S_IDLE)
                instr_count <= instr_count + 32'd1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   next_state = S_FETCH;
            S_FETCH:  next_state = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:                      next_state = S_MEM_ADDR;
                    OP_RTYPE:                          next_state = dec_legal ? S_R_EXEC : S_HALT;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: next_state = S_I_EXEC;
                    OP_BEQ:                            next_state = S_BRANCH;
                    OP_J:                              next_state = S_JUMP;
                    default:                           next_state = S_HALT;
                endcase
            end
            S_MEM_ADDR: next_state = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   next_state = S_MEM_WB;
            S_R_EXEC:   next_state = S_R_WB;
            S_I_EXEC:   next_state = S_I_WB;
            S_MEM_WB, S_MEM_WR, S_R_WB, S_I_WB, S_BRANCH, S_JUMP:
                        next_state = S_FETCH;
            S_HALT:     next_state = S_HALT;
            default:    next_state = S_IDLE;
        endcase
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        PCSource    = PCSRC_ALU;
        ALUSrcB     = SRCB_REG;
        ALUOp       = 4'b0000;
        halted      = 1'b0;
        case (state)
            S_FETCH: begin
                MemRead = 1'b1;
                IRWrite = 1'b1;
                ALUSrcB = SRCB_FOUR;
                ALUOp   = ALU_ADD;
                PCWrite = 1'b1;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_IMM_SH;
                ALUOp   = ALU_ADD;
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALU_ADD;
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_R_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = dec_alu_op;
            end
            S_R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_I_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = dec_alu_op;
            end
            S_I_WB:   RegWrite = 1'b1;
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PCSRC_JUMP;
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-cycle control words predicted from an instruction-level model.
module tb_multicycle_control;

    typedef struct packed {
        logic       pcw, pcwc, iord, mr, mw, irw, m2r, asa, rw, rd;
        logic [1:0] pcs, asb;
        logic [3:0] aop;
        logic       halt;
    } ctl_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] IReg_out = 32'd0;
    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic        MemtoReg, ALUSrcA, RegWrite, RegDst, halted;
    logic [1:0]  PCSource, ALUSrcB;
    logic [3:0]  ALUOp;
    logic [31:0] instr_count;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_count = 32'd0;
    bit          after_reset = 1'b1;
    ctl_t        exp_q[$];

    multicycle_control dut (
        .clk(clk), .reset(reset), .IReg_out(IReg_out),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
        .RegDst(RegDst), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .halted(halted), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic ctl_t observed();
        ctl_t o;
        o = '{PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
              ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp, halted};
        return o;
    endfunction

    // Instruction-level model: queue the control word expected in each cycle of ir.
    // Returns 1 when the instruction is illegal (only FETCH/DECODE are queued).
    function automatic bit plan(input logic [31:0] ir);
        ctl_t c;
        logic [5:0] op, fn;
        logic [3:0] aop;
        op = ir[31:26];
        fn = ir[5:0];
        c = '0; c.mr = 1; c.irw = 1; c.asb = 2'b01; c.aop = 4'b0010; c.pcw = 1;
        exp_q.push_back(c);
        c = '0; c.asb = 2'b11; c.aop = 4'b0010;
        exp_q.push_back(c);
        if (op == 6'h23 || op == 6'h2B) begin
            c = '0; c.asa = 1; c.asb = 2'b10; c.aop = 4'b0010; exp_q.push_back(c);
            if (op == 6'h23) begin
                c = '0; c.mr = 1; c.iord = 1; exp_q.push_back(c);
                c = '0; c.rw = 1; c.m2r = 1;  exp_q.push_back(c);
            end else begin
                c = '0; c.mw = 1; c.iord = 1; exp_q.push_back(c);
            end
            return 1'b0;
        end
        if (op == 6'h00) begin
            case (fn)
                6'h20: aop = 4'b0010;
                6'h22: aop = 4'b0110;
                6'h24: aop = 4'b0000;
                6'h25: aop = 4'b0001;
                6'h2A: aop = 4'b0111;
                default: return 1'b1;
            endcase
            c = '0; c.asa = 1; c.aop = aop; exp_q.push_back(c);
            c = '0; c.rw = 1; c.rd = 1;     exp_q.push_back(c);
            return 1'b0;
        end
        case (op)
            6'h08: aop = 4'b0010;
            6'h0C: aop = 4'b0000;
            6'h0D: aop = 4'b0001;
            6'h0A: aop = 4'b0111;
            6'h04: begin
                c = '0; c.asa = 1; c.aop = 4'b0110; c.pcwc = 1; c.pcs = 2'b01;
                exp_q.push_back(c);
                return 1'b0;
            end
            6'h02: begin
                c = '0; c.pcw = 1; c.pcs = 2'b10; exp_q.push_back(c);
                return 1'b0;
            end
            default: return 1'b1;
        endcase
        c = '0; c.asa = 1; c.asb = 2'b10; c.aop = aop; exp_q.push_back(c);
        c = '0; c.rw = 1; exp_q.push_back(c);
        return 1'b0;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        check("reset_ctl", 32'(observed()), 32'd0);
        check("reset_count", instr_count, 32'd0);
        reset = 1'b0;
        after_reset = 1'b1;
        exp_count = 32'd0;
        exp_q.delete();
    endtask

    // Run ir for at most max_cycles cycles (0 = whole instruction, plus 20 HALT cycles if illegal).
    task automatic run_instr(input logic [31:0] ir, input int max_cycles);
        bit bad;
        int n;
        ctl_t c;
        bad = plan(ir);
        n = 0;
        while (exp_q.size() > 0 && (max_cycles == 0 || n < max_cycles)) begin
            @(posedge clk); #1;
            if (n == 0) begin
                IReg_out = ir;
                if (!after_reset) exp_count = exp_count + 32'd1;
                after_reset = 1'b0;
            end
            c = exp_q.pop_front();
            check($sformatf("ctl ir=%h cyc%0d", ir, n), 32'(observed()), 32'(c));
            check("count", instr_count, exp_count);
            n++;
        end
        exp_q.delete();
        if (bad && max_cycles == 0) begin
            c = '0; c.halt = 1;
            for (int i = 0; i < 20; i++) begin
                @(posedge clk); #1;
                check($sformatf("halt ir=%h cyc%0d", ir, i), 32'(observed()), 32'(c));
                check("halt_count", instr_count, exp_count);
            end
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] ops[9] = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h23, 6'h2B, 6'h04, 6'h02};
        logic [5:0] fns[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        logic [31:0] ir;
        ir = $urandom;
        if ($urandom_range(0, 11) == 0) begin
            if ($urandom_range(0, 1) == 0) ir[31:26] = 6'h3F;
            else begin ir[31:26] = 6'h00; ir[5:0] = 6'h2F; end
        end else begin
            ir[31:26] = ops[$urandom_range(0, 8)];
            if (ir[31:26] == 6'h00) ir[5:0] = fns[$urandom_range(0, 4)];
        end
        return ir;
    endfunction

    initial begin
        logic [31:0] ir;
        do_reset();
        run_instr(32'h01095020, 0);
        run_instr(32'h8D090004, 0);
        run_instr(32'hAD090004, 0);
        run_instr(32'h11090003, 0);
        run_instr(32'h08000010, 0);
        @(posedge clk); #1;
        exp_count = exp_count + 32'd1;
        check("count_after_j", instr_count, exp_count);
        check("fetch_after_j", 32'(MemRead & IRWrite & PCWrite), 32'd1);
        IReg_out = 32'hFC000000;
        after_reset = 1'b1;
        // The FETCH above was already consumed; run DECODE onward by hand.
        @(posedge clk); #1;
        check("decode_bad_op", 32'(ALUSrcB), 32'd3);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("halt_bad_op", 32'(halted), 32'd1);
            check("halt_bad_op_ctl", 32'(observed()) >> 1, 32'd0);
            check("halt_bad_op_count", instr_count, exp_count);
        end
        do_reset();
        run_instr(32'h0109502F, 0);
        do_reset();
        run_instr(32'h01095020, 0);
        run_instr(32'h8D090004, 4);
        reset = 1'b1;
        @(posedge clk); #1;
        check("midreset_ctl", 32'(observed()), 32'd0);
        check("midreset_regwrite", 32'(RegWrite), 32'd0);
        check("midreset_count", instr_count, 32'd0);
        reset = 1'b0;
        after_reset = 1'b1;
        exp_count = 32'd0;
        for (int k = 0; k < 150; k++) begin
            ir = rand_instr();
            run_instr(ir, 0);
            if (halted === 1'b1) do_reset();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
